serial_demux_rx: RTL and testbench

SERIAL_DEMUX_RX -- requirements
Module: serial_demux_rx

---
 rtl/serial_demux_pkg.sv | 21 ++
 rtl/serial_demux_ctrl.sv | 69 ++++++
 rtl/serial_demux_rx.sv | 105 ++++++++++
 tb/tb_serial_demux_rx.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/serial_demux_pkg.sv
// Shared definitions for the serial frame demultiplexer: FSM encoding and default field widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_demux_pkg;

    localparam int PORT_BITS_DEF = 2;
    localparam int LEN_BITS_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PORT = 2'd1,
        ST_LEN  = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    // Width of a counter that must reach the larger of the two header field widths.
    function automatic int fld_cnt_width(input int a, input int b);
        fld_cnt_width = $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/serial_demux_ctrl.sv
// Frame-sequencing FSM: IDLE -> PORT -> LEN -> (DATA) -> IDLE, advancing only on enabled cycles.
// Latency: state, busy and done are registered; done appears the cycle after the final bit is sampled.
// Backpressure: none; clk_en low freezes the FSM while done still self-clears after one cycle.
module serial_demux_ctrl
    import serial_demux_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clk_en,
    input  logic   serin,
    input  logic   port_last,
    input  logic   len_last,
    input  logic   len_nz,
    input  logic   data_last,
    output state_t state,
    output logic   busy,
    output logic   done
);

    // State transitions with registered busy/done derived from the transition taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clk_en) begin
                case (state)
                    ST_IDLE: begin
                        if (!serin) begin
                            state <= ST_PORT;
                            busy  <= 1'b1;
                        end
                    end
                    ST_PORT: begin
                        if (port_last) begin
                            state <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (len_last) begin
                            if (len_nz) begin
                                state <= ST_DATA;
                            end else begin
                                // Zero-length frame ends right after the header.
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (data_last) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/serial_demux_rx.sv
// Serial frame receiver: decodes start/port/length header and steers N data bits to a one-hot channel valid.
// Latency: ser_out is combinational; out_valid follows the registered state; done one cycle after the last bit.
// Backpressure: none; the bit rate is set by clk_en and all header/counter state freezes while it is low.
module serial_demux_rx
    import serial_demux_pkg::*;
#(
    parameter  int PORT_BITS = PORT_BITS_DEF,
    parameter  int LEN_BITS  = LEN_BITS_DEF,
    localparam int NUM_PORTS = 2 ** PORT_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 serin,
    output logic                 ser_out,
    output logic [NUM_PORTS-1:0] out_valid,
    output logic [PORT_BITS-1:0] port_out,
    output logic [LEN_BITS-1:0]  len_out,
    output logic                 busy,
    output logic                 done
);

    localparam int FLD_W = fld_cnt_width(PORT_BITS, LEN_BITS);

    state_t               state;
    logic [FLD_W-1:0]     fld_cnt;
    logic [LEN_BITS-1:0]  data_cnt;
    logic [PORT_BITS-1:0] port_next;
    logic [LEN_BITS-1:0]  len_next;
    logic                 port_last;
    logic                 len_last;
    logic                 len_nz;
    logic                 data_last;

    assign ser_out   = serin;

    // MSB-first shift: the register value after absorbing the current serial bit.
    assign port_next = (port_out << 1) | PORT_BITS'(serin);
    assign len_next  = (len_out << 1) | LEN_BITS'(serin);

    assign port_last = (fld_cnt == FLD_W'(PORT_BITS - 1));
    assign len_last  = (fld_cnt == FLD_W'(LEN_BITS - 1));
    // Decided on the final length bit, so it must look at the value including that bit.
    assign len_nz    = |len_next;
    assign data_last = (data_cnt == LEN_BITS'(1));

    serial_demux_ctrl u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .serin     (serin),
        .port_last (port_last),
        .len_last  (len_last),
        .len_nz    (len_nz),
        .data_last (data_last),
        .state     (state),
        .busy      (busy),
        .done      (done)
    );

    // Header capture: port/length shift registers and the shared field bit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port_out <= '0;
            len_out  <= '0;
            fld_cnt  <= '0;
        end else if (clk_en) begin
            case (state)
                ST_PORT: begin
                    port_out <= port_next;
                    fld_cnt  <= port_last ? '0 : fld_cnt + FLD_W'(1);
                end
                ST_LEN: begin
                    len_out <= len_next;
                    fld_cnt <= len_last ? '0 : fld_cnt + FLD_W'(1);
                end
                default: begin
                    fld_cnt <= '0;
                end
            endcase
        end
    end

    // Data counter: loaded with the full length on the last header bit, counts down through DATA.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_cnt <= '0;
        end else if (clk_en) begin
            if (state == ST_LEN && len_last) begin
                data_cnt <= len_next;
            end else if (state == ST_DATA) begin
                data_cnt <= data_cnt - LEN_BITS'(1);
            end
        end
    end

    // One-hot channel valid, asserted for the whole data phase regardless of clk_en.
    always_comb begin
        out_valid = '0;
        if (state == ST_DATA) begin
            out_valid[port_out] = 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_demux_rx.sv
// Bench for serial_demux_rx: directed frames plus randomized frames against a frame-position model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_serial_demux_rx;

    localparam int PB  = 2;
    localparam int LB  = 4;
    localparam int NP  = 4;
    localparam int HDR = 1 + PB + LB;

    logic          clk    = 1'b0;
    logic          rst    = 1'b0;
    logic          clk_en = 1'b0;
    logic          serin  = 1'b1;
    wire           ser_out;
    wire  [NP-1:0] out_valid;
    wire  [PB-1:0] port_out;
    wire  [LB-1:0] len_out;
    wire           busy;
    wire           done;

    int            checks = 0;
    int            errors = 0;
    logic [PB-1:0] exp_port = '0;
    logic [LB-1:0] exp_len  = '0;

    serial_demux_rx #(.PORT_BITS(PB), .LEN_BITS(LB)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .serin     (serin),
        .ser_out   (ser_out),
        .out_valid (out_valid),
        .port_out  (port_out),
        .len_out   (len_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs once c bits of a frame (port p, total bits) have been consumed.
    function automatic logic [NP-1:0] valid_at(input int c, input int total, input int p);
        valid_at = (c >= HDR && c < total) ? (NP'(1) << p) : '0;
    endfunction

    function automatic logic busy_at(input int c, input int total);
        busy_at = (c >= 1 && c < total);
    endfunction

    function automatic logic fields_stable(input int c);
        fields_stable = (c == 0 || c >= HDR);
    endfunction

    // One clk cycle, entered and left at a negedge; outputs checked at the following negedge.
    task automatic step(input logic en, input logic b, input logic [NP-1:0] ev,
                        input logic eb, input logic ed, input logic cf);
        clk_en = en;
        serin  = b;
        #1;
        chk("ser_out", ser_out, b);
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", out_valid, ev);
        chk("busy", busy, eb);
        chk("done", done, ed);
        if (cf) begin
            chk("port_out", port_out, exp_port);
            chk("len_out", len_out, exp_len);
        end
    endtask

    // Idle line (serin=1) for cnt enabled cycles, with stride-1 disabled cycles before each.
    task automatic idle(input int cnt, input int stride);
        for (int i = 0; i < cnt; i++) begin
            repeat (stride - 1) step(1'b0, 1'($urandom), '0, 1'b0, 1'b0, 1'b1);
            step(1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    // Sends the first `limit` bits of a frame; disabled cycles carry random serin that must be ignored.
    task automatic send_frame(input int p, input int n, input logic [15:0] data,
                              input int stride, input int limit);
        int   total;
        logic bits[$];
        total = HDR + n;
        bits.push_back(1'b0);
        for (int i = PB - 1; i >= 0; i--) bits.push_back(1'(p >> i));
        for (int i = LB - 1; i >= 0; i--) bits.push_back(1'(n >> i));
        for (int j = 0; j < n; j++) bits.push_back(data[j]);
        for (int k = 0; k < limit; k++) begin
            repeat (stride - 1)
                step(1'b0, 1'($urandom), valid_at(k, total, p), busy_at(k, total), 1'b0, fields_stable(k));
            if (k + 1 == HDR) begin
                exp_port = PB'(p);
                exp_len  = LB'(n);
            end
            step(1'b1, bits[k], valid_at(k + 1, total, p), busy_at(k + 1, total),
                 (k + 1 == total), fields_stable(k + 1));
        end
    endtask

    initial begin
        int p, n, stride, gap;
        logic [15:0] d;

        @(negedge clk);
        #1;
        chk("rst_valid", out_valid, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_port", port_out, '0);
        chk("rst_len", len_out, '0);
        @(negedge clk);
        rst = 1'b1;

        // Idle line after reset.
        idle(20, 1);

        // Port 2, length 3, data 1,0,1.
        send_frame(2, 3, 16'b101, 1, HDR + 3);
        idle(2, 1);

        // Zero-length frame to port 1.
        send_frame(1, 0, 16'h0, 1, HDR);
        idle(2, 1);

        // Back-to-back: port 3 len 15, then port 0 len 1.
        send_frame(3, 15, 16'($urandom), 1, HDR + 15);
        send_frame(0, 1, 16'($urandom), 1, HDR + 1);
        idle(2, 1);

        // Enable every third clk.
        send_frame(2, 3, 16'b101, 3, HDR + 3);
        idle(2, 3);

        // Reset during the second data bit.
        send_frame(2, 3, 16'b101, 1, HDR + 1);
        rst = 1'b0;
        #1;
        chk("arst_valid", out_valid, '0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_port", port_out, '0);
        chk("arst_len", len_out, '0);
        exp_port = '0;
        exp_len  = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        send_frame(2, 3, 16'b101, 1, HDR + 3);
        idle(1, 1);

        // Randomized frames, strides and gaps (gap 0 exercises back-to-back starts).
        for (int f = 0; f < 40; f++) begin
            p      = int'($urandom_range(0, NP - 1));
            n      = int'($urandom_range(0, (1 << LB) - 1));
            stride = int'($urandom_range(1, 3));
            gap    = int'($urandom_range(0, 3));
            d      = 16'($urandom);
            send_frame(p, n, d, stride, HDR + n);
            idle(gap, stride);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
